// File: rtl/serial_mod_detector_pkg.sv
// Shared definitions for the serial divisibility detector: frame bit order,
// the width helper, and the divisor legality check used at elaboration.
package serial_mod_detector_pkg;

  typedef enum logic {
    MODE_MSB = 1'b0,
    MODE_LSB = 1'b1
  } mode_e;

  localparam int DIVISOR_MIN = 2;
  localparam int DIVISOR_MAX = 255;

  // Smallest width able to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic bit divisor_ok(input int d);
    return (d >= DIVISOR_MIN) && (d <= DIVISOR_MAX);
  endfunction

endpackage

// File: rtl/serial_mod_detector_mod_reduce.sv
// Reduces an operand known to be below 2*DIVISOR to its value mod DIVISOR
// with a single conditional subtract.
module mod_reduce #(
  parameter int DIVISOR = 4,
  parameter int REM_W   = 2
) (
  input  logic [REM_W:0]   op_i,
  output logic [REM_W-1:0] res_o
);

  localparam logic [REM_W:0] DIV_W = (REM_W + 1)'(DIVISOR);

  // The true difference always fits in REM_W bits, so subtracting in the
  // narrow width (modulo 2^REM_W) yields the exact result.
  always_comb begin
    if (op_i >= DIV_W) begin
      res_o = op_i[REM_W-1:0] - DIV_W[REM_W-1:0];
    end else begin
      res_o = op_i[REM_W-1:0];
    end
  end

endmodule

// File: rtl/serial_mod_detector.sv
// Serial divisibility detector: tracks the running remainder of a bit-serial
// number modulo DIVISOR, MSB-first or LSB-first, with framed results.
module serial_mod_detector
  import serial_mod_detector_pkg::*;
#(
  parameter int DIVISOR = 4,
  parameter int CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           din_valid,
  input  logic                           din,
  input  logic                           sof,
  input  logic                           eof,
  input  logic                           lsb_first,
  output logic [clog2(DIVISOR)-1:0]      remainder,
  output logic                           divisible,
  output logic [CNT_W-1:0]               bit_count,
  output logic                           result_valid,
  output logic                           result_divisible
);

  localparam int REM_W = clog2(DIVISOR);

  if (!divisor_ok(DIVISOR)) begin : g_bad_divisor
    $error("serial_mod_detector: DIVISOR must be within 2..255");
  end

  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] w_q, w_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic             rd_q, rd_d;

  // A valid sof restarts the arithmetic from r=0, w=1 on this very bit.
  logic             sof_v;
  logic [REM_W-1:0] r_in, w_in;
  mode_e            mode_eff;
  logic [REM_W:0]   t_msb, s_lsb, w_dbl;
  logic [REM_W-1:0] r_msb, r_lsb, w_next, r_new;

  assign sof_v    = din_valid & sof;
  assign r_in     = sof_v ? '0 : rem_q;
  assign w_in     = sof_v ? REM_W'(1) : w_q;
  assign mode_eff = sof_v ? mode_e'(lsb_first) : mode_q;

  assign t_msb = {r_in, din};
  assign s_lsb = {1'b0, r_in} + (din ? {1'b0, w_in} : '0);
  assign w_dbl = {w_in, 1'b0};

  mod_reduce #(.DIVISOR(DIVISOR), .REM_W(REM_W)) u_msb (.op_i(t_msb), .res_o(r_msb));
  mod_reduce #(.DIVISOR(DIVISOR), .REM_W(REM_W)) u_lsb (.op_i(s_lsb), .res_o(r_lsb));
  mod_reduce #(.DIVISOR(DIVISOR), .REM_W(REM_W)) u_wgt (.op_i(w_dbl), .res_o(w_next));

  assign r_new = (mode_eff == MODE_LSB) ? r_lsb : r_msb;

  // Next-state: accept a bit, close a frame on eof, otherwise hold.
  always_comb begin
    rem_d  = rem_q;
    w_d    = w_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    rv_d   = 1'b0;
    rd_d   = rd_q;
    if (din_valid) begin
      mode_d = mode_eff;
      if (eof) begin
        rem_d = '0;
        w_d   = REM_W'(1);
        cnt_d = '0;
        rv_d  = 1'b1;
        rd_d  = (r_new == '0);
      end else begin
        rem_d = r_new;
        w_d   = (mode_eff == MODE_LSB) ? w_next : w_in;
        if (sof_v) begin
          cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset drops any frame in progress without a result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q  <= '0;
      w_q    <= REM_W'(1);
      mode_q <= MODE_MSB;
      cnt_q  <= '0;
      rv_q   <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      w_q    <= w_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      rv_q   <= rv_d;
      rd_q   <= rd_d;
    end
  end

  assign remainder        = rem_q;
  assign divisible        = (rem_q == '0);
  assign bit_count        = cnt_q;
  assign result_valid     = rv_q;
  assign result_divisible = rd_q;

endmodule

// File: doc/serial_mod_detector.md
Name: serial_mod_detector

Overview:
Parametrised serial divisibility detector. Accepts a binary number one bit per valid cycle and tracks its running remainder modulo DIVISOR. Supports MSB-first and LSB-first framing, explicit start-of-frame and end-of-frame markers, and a per-frame result pulse. It is the generalised successor of the fixed divide-by-4 stream detector and sits on serial data inputs ahead of frame-check logic.

Parameters:
DIVISOR, 4, modulus; legal range 2..255; any integer, not only powers of two.
CNT_W, 16, width of the accepted-bit counter.
REM_W, clog2(DIVISOR), derived localparam; width of the remainder and weight registers.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  reset; asynchronous, active-low.
din_valid  in  1  din is accepted this cycle when high.
din  in  1  serial data bit.
sof  in  1  start of frame; qualified by din_valid; this bit is the first bit of a new number.
eof  in  1  end of frame; qualified by din_valid; this bit is the last bit of the number.
lsb_first  in  1  frame bit order; sampled only on a valid sof; 0 = MSB-first.
remainder  out  REM_W  running value mod DIVISOR after the last accepted bit.
divisible  out  1  (remainder == 0); combinational from the register.
bit_count  out  CNT_W  bits accepted in the current frame; saturates at all-ones.
result_valid  out  1  one-cycle pulse, the cycle after a valid eof.
result_divisible  out  1  divisibility of the last completed frame; held until the next result.

Behaviour:
- Reset values: remainder=0, weight=1, mode=MSB, bit_count=0, result_valid=0, result_divisible=0. divisible=1 in reset.
- All updates require din_valid=1. When din_valid=0, all state holds. sof and eof without din_valid are ignored.
- Latency: each accepted bit is reflected on remainder, divisible and bit_count in the next cycle.
- MSB mode update: t = 2*r + din, REM_W+1 bits wide; r' = t - DIVISOR if t >= DIVISOR, else t. The bound is t <= 2*DIVISOR-1, so one conditional subtract is sufficient.
- LSB mode update: s = r + (din ? w : 0); r' = s mod DIVISOR. Then w' = 2*w mod DIVISOR. Each step uses a single conditional subtract.
- On a valid sof, the frame restarts:
  - The update uses r=0 and w=1 as its inputs.
  - mode <= lsb_first.
  - bit_count <= 1.
  - Any in-progress frame is discarded without a result.
- Without a sof since reset, the block runs in MSB mode from r=0. With DIVISOR=4 and din_valid tied high, divisible matches the legacy divide-by-4 detector cycle for cycle.
- On a valid eof (the bit is included), the next cycle has:
  - result_valid=1.
  - result_divisible = (r' == 0).
  - Next state: r=0, w=1, bit_count=0, mode unchanged. A following bit without sof starts a new frame in the same mode.
- sof and eof in the same valid cycle form a single-bit frame: result = (din mod DIVISOR == 0).
- lsb_first changes outside a valid sof have no effect.
- bit_count saturates at 2^CNT_W-1; the remainder keeps updating.
- rstn assertion mid-frame: immediate return to reset values; no result pulse is produced.
- No state machine beyond the mode bit. The remainder register is the state, with DIVISOR states.

Decomposition:
- Shared package holds:
  - the clog2 function,
  - the MODE_MSB and MODE_LSB constants,
  - the DIVISOR legality check, an elaboration-time error for DIVISOR < 2.
- One sub-module, mod_reduce: it takes an REM_W+1-bit operand less than 2*DIVISOR and returns the operand mod DIVISOR via a conditional subtract. There are three instances: the MSB path, the LSB sum and the weight doubling.

Test Plan:
- DIVISOR=4, din_valid tied high, no sof, bits 1,1,0,0 (value 12) -> remainder 1,3,2,0; divisible 0,0,0,1; bit_count 1,2,3,4.
- DIVISOR=3, MSB: sof on bit 1, then 0,0, then 1 with eof (value 9) -> remainder 1,2,1,0; result_valid pulses once; result_divisible=1; bit_count returns to 0.
- DIVISOR=5, lsb_first=1: sof on bit 1, then 0,1, then 1 with eof (value 13) -> weight 1,2,4,3; remainder 1,1,0,3; result_divisible=0.
- DIVISOR=3, MSB, bits 1,1 with din_valid=0 gaps of 3 cycles between them -> remainder holds 1 during the gaps, becomes 0 after the second bit; bit_count holds during the gaps.
- DIVISOR=7, sof mid-frame after three bits, then bit 1 with eof -> remainder 1; result_divisible=0. Then rstn pulse mid-frame -> remainder 0, bit_count 0, no result_valid.
- DIVISOR=6, sof+eof same cycle with din=0 -> result_valid=1, result_divisible=1. Repeat with din=1 -> result_divisible=0.
